// File: rtl/alu64b_stage.sv
// ---------------------------------------------------------------------------
// alu64b_stage
//   Single-cycle 64-bit ALU followed by a 2-entry result FIFO with a
//   valid/ready handshake on both sides. Results are computed
//   combinationally from the operands and captured on a push. The head of
//   the FIFO drives result/zero. op_count tallies results consumed
//   downstream.
// ---------------------------------------------------------------------------
module alu64b_stage (
    input  logic        clk,
    input  logic        reset,

    // Upstream operand side
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  op,
    input  logic [63:0] a,
    input  logic [63:0] b,

    // Downstream result side
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] result,
    output logic        zero,

    // Number of results consumed since reset
    output logic [31:0] op_count
);

    // -----------------------------------------------------------------------
    // Operation encoding
    // -----------------------------------------------------------------------
    typedef enum logic [2:0] {
        OP_ADD   = 3'b000,
        OP_SUB   = 3'b001,
        OP_XOR   = 3'b010,
        OP_OR    = 3'b011,
        OP_AND   = 3'b100,
        OP_SLT   = 3'b101,
        OP_SLTU  = 3'b110,
        OP_PASSB = 3'b111
    } op_e;

    localparam logic [1:0] COUNT_EMPTY = 2'd0;
    localparam logic [1:0] COUNT_FULL  = 2'd2;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [1:0]  count_q,    count_d;
    logic        wr_ptr_q,   wr_ptr_d;
    logic        rd_ptr_q,   rd_ptr_d;
    logic [31:0] op_count_q, op_count_d;
    logic [63:0] mem_q [2];

    // -----------------------------------------------------------------------
    // Handshake qualifiers
    // -----------------------------------------------------------------------
    logic        push;
    logic        pop;
    logic [63:0] alu_res;
    logic        slt_bit;
    logic        sltu_bit;

    // in_ready depends only on registered occupancy, so there is never a
    // combinational path from out_ready back to in_ready.
    assign in_ready  = (count_q != COUNT_FULL);
    assign out_valid = (count_q != COUNT_EMPTY);

    assign push = in_valid  & in_ready;
    assign pop  = out_valid & out_ready;

    // Head of FIFO. Storage is not reset, so zero must be qualified by
    // out_valid to stay low while the buffer is empty.
    assign result   = mem_q[rd_ptr_q];
    assign zero     = out_valid & (mem_q[rd_ptr_q] == 64'd0);
    assign op_count = op_count_q;

    // -----------------------------------------------------------------------
    // ALU datapath
    // -----------------------------------------------------------------------
    assign slt_bit  = ($signed(a) < $signed(b));
    assign sltu_bit = (a < b);

    // Select the ALU result for the requested operation.
    always_comb begin
        // NOTE: every variable written here gets a default first so that no
        // path through the case can leave it unassigned and infer a latch.
        alu_res = 64'd0;
        case (op_e'(op))
            OP_ADD:   alu_res = a + b;
            OP_SUB:   alu_res = a - b;
            OP_XOR:   alu_res = a ^ b;
            OP_OR:    alu_res = a | b;
            OP_AND:   alu_res = a & b;
            OP_SLT:   alu_res = {63'd0, slt_bit};
            OP_SLTU:  alu_res = {63'd0, sltu_bit};
            OP_PASSB: alu_res = b;
            default:  alu_res = 64'd0;
        endcase
    end

    // -----------------------------------------------------------------------
    // FIFO control next-state
    // -----------------------------------------------------------------------

    // Compute occupancy, pointer and consumed-count updates for this edge.
    always_comb begin
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        op_count_d = op_count_q;

        // Pointers are 1 bit wide and wrap naturally modulo 2.
        if (push) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d   = ~rd_ptr_q;
            op_count_d = op_count_q + 32'd1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Control registers; cleared asynchronously so the handshake outputs
    // go idle as soon as reset rises, without waiting for a clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q    <= COUNT_EMPTY;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            op_count_q <= 32'd0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            op_count_q <= op_count_d;
        end
    end

    // Capture the ALU result into the slot addressed by the write pointer.
    // NOTE: the data array carries no reset; its contents are only observed
    // once out_valid is high, and leaving it unreset keeps it plain RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= alu_res;
        end
    end

endmodule

// File: tb/tb_alu64b_stage.sv
// ---------------------------------------------------------------------------
// tb_alu64b_stage
//   Scoreboard bench for alu64b_stage. Expected results are queued when an
//   operation is accepted and compared in order when the DUT presents them.
// ---------------------------------------------------------------------------
module tb_alu64b_stage;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result;
    logic        zero;
    logic [31:0] op_count;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] sb_q[$];
    logic [31:0] m_op_count = 32'd0;

    localparam logic [63:0] XA = 64'hFFFF0000FFFF0000;
    localparam logic [63:0] XB = 64'h0F0F0F0F0F0F0F0F;

    alu64b_stage dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .op_count  (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Golden ALU model.
    function automatic logic [63:0] golden(input logic [2:0] o, input logic [63:0] x, input logic [63:0] y);
        logic lt;
        case (o)
            3'd0: return x + y;
            3'd1: return x + ~y + 64'd1;
            3'd2: return x ^ y;
            3'd3: return x | y;
            3'd4: return x & y;
            3'd5: begin
                if (x[63] != y[63]) lt = x[63];
                else                lt = (x[62:0] < y[62:0]);
                return lt ? 64'd1 : 64'd0;
            end
            3'd6: return (x < y) ? 64'd1 : 64'd0;
            default: return y;
        endcase
    endfunction

    task automatic set_in(input logic v, input logic [2:0] o, input logic [63:0] x,
                          input logic [63:0] y, input logic r);
        in_valid  = v;
        op        = o;
        a         = x;
        b         = y;
        out_ready = r;
    endtask

    // One clock: compare outputs against the scoreboard at the falling edge,
    // update the model across the rising edge, return 1 time unit after it.
    task automatic tick();
        logic        exp_in_ready;
        logic        exp_out_valid;
        logic        do_push;
        logic        do_pop;
        logic [63:0] exp_res;
        @(negedge clk);
        exp_in_ready  = (sb_q.size() < 2);
        exp_out_valid = (sb_q.size() > 0);
        checks++;
        if (in_ready !== exp_in_ready) begin
            errors++;
            $display("FAIL in_ready: got %b expected %b", in_ready, exp_in_ready);
        end
        checks++;
        if (out_valid !== exp_out_valid) begin
            errors++;
            $display("FAIL out_valid: got %b expected %b", out_valid, exp_out_valid);
        end
        checks++;
        if (op_count !== m_op_count) begin
            errors++;
            $display("FAIL op_count: got %0d expected %0d", op_count, m_op_count);
        end
        if (exp_out_valid) begin
            checks++;
            if (result !== sb_q[0]) begin
                errors++;
                $display("FAIL sb_result: got %h expected %h", result, sb_q[0]);
            end
            checks++;
            if (zero !== (sb_q[0] == 64'd0)) begin
                errors++;
                $display("FAIL sb_zero: got %b expected %b", zero, (sb_q[0] == 64'd0));
            end
        end else begin
            checks++;
            if (zero !== 1'b0) begin
                errors++;
                $display("FAIL zero_empty: got %b expected 0", zero);
            end
        end
        do_push = in_valid && exp_in_ready;
        do_pop  = out_ready && exp_out_valid;
        exp_res = golden(op, a, b);
        @(posedge clk);
        if (do_pop) begin
            void'(sb_q.pop_front());
            m_op_count++;
        end
        if (do_push) sb_q.push_back(exp_res);
        #1;
    endtask

    task automatic drain();
        set_in(1'b0, 3'd0, 64'd0, 64'd0, 1'b1);
        for (int i = 0; i < 4; i++) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_in(1'b0, 3'd0, 64'd0, 64'd0, 1'b0);
        #2;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || zero !== 1'b0 || op_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: got ov=%b ir=%b z=%b cnt=%0d expected ov=0 ir=1 z=0 cnt=0",
                     out_valid, in_ready, zero, op_count);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb_q.delete();
        m_op_count = 32'd0;
    endtask

    task automatic test_xor();
        set_in(1'b1, 3'b010, XA, XB, 1'b1);
        tick();
        set_in(1'b0, 3'd0, 64'd0, 64'd0, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || result !== 64'hF0F00F0FF0F00F0F || zero !== 1'b0) begin
            errors++;
            $display("FAIL xor_result: got ov=%b res=%h z=%b expected ov=1 res=f0f00f0ff0f00f0f z=0",
                     out_valid, result, zero);
        end
        tick();
        checks++;
        if (op_count !== 32'd1) begin
            errors++;
            $display("FAIL xor_op_count: got %0d expected 1", op_count);
        end
    endtask

    task automatic test_arith();
        set_in(1'b1, 3'b000, 64'hFFFFFFFFFFFFFFFF, 64'd1, 1'b1);
        tick();
        checks++;
        if (result !== 64'd0 || zero !== 1'b1) begin
            errors++;
            $display("FAIL add_wrap: got res=%h z=%b expected res=0 z=1", result, zero);
        end
        set_in(1'b1, 3'b001, 64'd0, 64'd1, 1'b1);
        tick();
        checks++;
        if (result !== 64'hFFFFFFFFFFFFFFFF || zero !== 1'b0) begin
            errors++;
            $display("FAIL sub_wrap: got res=%h z=%b expected res=ffffffffffffffff z=0", result, zero);
        end
        set_in(1'b1, 3'b101, 64'hFFFFFFFFFFFFFFFF, 64'd1, 1'b1);
        tick();
        checks++;
        if (result !== 64'd1) begin
            errors++;
            $display("FAIL slt_neg: got %h expected 1", result);
        end
        set_in(1'b1, 3'b110, 64'hFFFFFFFFFFFFFFFF, 64'd1, 1'b1);
        tick();
        checks++;
        if (result !== 64'd0 || zero !== 1'b1) begin
            errors++;
            $display("FAIL sltu_big: got res=%h z=%b expected res=0 z=1", result, zero);
        end
        drain();
    endtask

    task automatic test_backpressure();
        set_in(1'b1, 3'b010, XA, XB, 1'b0);
        tick();
        set_in(1'b1, 3'b011, XA, XB, 1'b0);
        tick();
        checks++;
        if (in_ready !== 1'b0 || result !== 64'hF0F00F0FF0F00F0F) begin
            errors++;
            $display("FAIL bp_full: got ir=%b res=%h expected ir=0 res=f0f00f0ff0f00f0f", in_ready, result);
        end
        set_in(1'b1, 3'b100, XA, XB, 1'b0);
        tick();
        checks++;
        if (in_ready !== 1'b0 || result !== 64'hF0F00F0FF0F00F0F) begin
            errors++;
            $display("FAIL bp_hold: got ir=%b res=%h expected ir=0 res=f0f00f0ff0f00f0f", in_ready, result);
        end
        set_in(1'b1, 3'b100, XA, XB, 1'b1);
        tick();
        checks++;
        if (result !== 64'hFFFF0F0FFFFF0F0F || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_or_head: got res=%h ir=%b expected res=ffff0f0fffff0f0f ir=1", result, in_ready);
        end
        tick();
        checks++;
        if (result !== 64'h0F0F00000F0F0000 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_and_head: got res=%h ov=%b expected res=0f0f00000f0f0000 ov=1", result, out_valid);
        end
        drain();
    endtask

    task automatic test_stream();
        test_reset();
        for (int i = 0; i < 1000; i++) begin
            set_in(1'b1, 3'($urandom_range(0, 7)), {$urandom(), $urandom()}, {$urandom(), $urandom()}, 1'b1);
            tick();
        end
        set_in(1'b0, 3'd0, 64'd0, 64'd0, 1'b1);
        tick();
        checks++;
        if (op_count !== 32'd1000) begin
            errors++;
            $display("FAIL stream_count: got %0d expected 1000", op_count);
        end
    endtask

    task automatic test_midreset();
        set_in(1'b1, 3'b011, {$urandom(), $urandom()}, {$urandom(), $urandom()}, 1'b0);
        tick();
        tick();
        checks++;
        if (in_ready !== 1'b0 || op_count === 32'd0) begin
            errors++;
            $display("FAIL midrst_pre: got ir=%b cnt=%0d expected ir=0 cnt nonzero", in_ready, op_count);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || op_count !== 32'd0 || zero !== 1'b0) begin
            errors++;
            $display("FAIL midrst_async: got ov=%b ir=%b cnt=%0d z=%b expected ov=0 ir=1 cnt=0 z=0",
                     out_valid, in_ready, op_count, zero);
        end
        sb_q.delete();
        m_op_count = 32'd0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        set_in(1'b1, 3'b111, 64'd0, 64'h123456789ABCDEF0, 1'b0);
        tick();
        checks++;
        if (out_valid !== 1'b1 || result !== 64'h123456789ABCDEF0) begin
            errors++;
            $display("FAIL first_push: got ov=%b res=%h expected ov=1 res=123456789abcdef0", out_valid, result);
        end
        drain();
    endtask

    task automatic test_random();
        for (int i = 0; i < 1000; i++) begin
            set_in(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), {$urandom(), $urandom()},
                   {$urandom(), $urandom()}, 1'($urandom_range(0, 1)));
            tick();
        end
        drain();
        checks++;
        if (out_valid !== 1'b0 || op_count !== m_op_count) begin
            errors++;
            $display("FAIL random_drain: got ov=%b cnt=%0d expected ov=0 cnt=%0d", out_valid, op_count, m_op_count);
        end
    endtask

    initial begin
        test_reset();
        test_xor();
        test_arith();
        test_backpressure();
        test_stream();
        test_midreset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu64b_stage.md
ALU64B_STAGE -- requirements
Module: alu64b_stage

Interface
REQ-001 SHALL have no parameters; data width is fixed at 64 bits and buffer depth is fixed at 2 entries.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1 bit: upstream operand pair valid.
REQ-005 SHALL have port in_ready, output, 1 bit: stage can accept an operation.
REQ-006 SHALL have port op, input, 3 bits: operation select (encoding in REQ-014).
REQ-007 SHALL have ports a and b, inputs, 64 bits each: operands.
REQ-008 SHALL have port out_valid, output, 1 bit: result at head of buffer valid.
REQ-009 SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-010 SHALL have port result, output, 64 bits: head-of-buffer result.
REQ-011 SHALL have port zero, output, 1 bit: high when result == 0 and out_valid = 1, otherwise low.
REQ-012 SHALL have port op_count, output, 32 bits: number of results consumed downstream since reset.

Function
REQ-013 SHALL compute the result combinationally from a, b and op, and write it into a 2-entry FIFO on a push (push = in_valid & in_ready).
REQ-014 SHALL use this op encoding: 000 ADD a+b; 001 SUB a-b; 010 XOR a^b; 011 OR a|b; 100 AND a&b; 101 SLT (signed a<b ? 1 : 0); 110 SLTU (unsigned a<b ? 1 : 0); 111 PASSB b.
REQ-015 SHALL truncate ADD and SUB to 64 bits modulo 2^64, with no carry or overflow output.
REQ-016 SHALL zero-extend the SLT and SLTU results to 64 bits.
REQ-017 SHALL keep an occupancy count in {0, 1, 2}.
REQ-018 SHALL drive in_ready = (count < 2), with no combinational path from out_ready to in_ready.
REQ-019 SHALL drive out_valid = (count > 0); result and zero reflect the oldest entry.
REQ-020 SHALL define a pop as out_valid & out_ready.
REQ-021 SHALL make a pushed entry visible on out_valid and result in the cycle after the push edge (latency 1 cycle).
REQ-022 SHALL update count per edge: push only +1; pop only -1; push and pop together unchanged.
REQ-023 SHALL, when push and pop occur together at count 1, make the new entry the head on the next cycle.
REQ-024 SHALL sustain a throughput of 1 operation per cycle while out_ready is held high.
REQ-025 SHALL, when count = 2, ignore in_valid (no push) and keep both entries unchanged until a pop.
REQ-026 SHALL, when count = 0, ignore out_ready, keep out_valid = 0 and leave op_count unchanged.
REQ-027 SHALL hold result stable while out_valid = 1 and out_ready = 0.
REQ-028 SHALL increment op_count by 1 on each pop, wrapping from 0xFFFFFFFF to 0.
REQ-029 SHALL manage FIFO read and write pointers as 1-bit values that wrap modulo 2.

Reset
REQ-030 SHALL, while reset = 1, immediately force count = 0, pointers = 0, op_count = 0, out_valid = 0, zero = 0 and in_ready = 1, independent of clk.
REQ-031 SHALL discard buffered entries on a reset asserted mid-operation; no pop is counted for them.
REQ-032 SHALL accept a push on the first rising edge after reset deasserts.
REQ-033 SHALL not reset the FIFO data storage; result is don't-care while out_valid = 0.

Verification
REQ-034 SHALL cover basic XOR: after reset, push op=010, a=0xFFFF0000FFFF0000, b=0x0F0F0F0F0F0F0F0F, out_ready=1 -> next cycle out_valid=1, result=0xF0F00F0FF0F00F0F, zero=0, and op_count=1 after the pop edge.
REQ-035 SHALL cover arithmetic and compare: ADD 0xFFFFFFFFFFFFFFFF+1 -> 0, zero=1; SUB 0-1 -> 0xFFFFFFFFFFFFFFFF; SLT a=-1, b=1 -> 1; SLTU a=-1, b=1 -> 0.
REQ-036 SHALL cover backpressure: out_ready=0 with three pushes offered (XOR, OR, AND) -> in_ready falls after 2 accepts, result holds the XOR value; then out_ready=1 -> XOR and OR results pop in order, after which the offered AND is accepted.
REQ-037 SHALL cover streaming: 1000 random ops with random a, b and in_valid/out_ready held at 1 -> one result per cycle, each matching the golden model in order, op_count=1000.
REQ-038 SHALL cover mid-operation reset: reset asserted asynchronously with count=2 -> out_valid=0, in_ready=1 and op_count=0 before the next edge.
REQ-039 SHALL cover random handshake: random in_valid/out_ready over 1000 cycles against a scoreboard -> no loss, duplication or reordering, and errors reported as 0.
